// File: rtl/pci_target_if.sv
// PCI target bus bundle: initiator handshake, command/byte enables and target responses.
// The multiplexed AD bus stays a plain inout port on the target so that tri-state
// resolution happens on an ordinary net.
interface pci_target_if;
  logic       frame;   // FRAME#, active low
  logic       irdy;    // IRDY#, active low
  logic [3:0] c_be;    // C/BE#: command in address phase, byte enables in data phases
  logic       trdy;    // TRDY#, active low
  logic       devsel;  // DEVSEL#, active low

  modport master (
    output frame,
    output irdy,
    output c_be,
    input  trdy,
    input  devsel
  );

  modport slave (
    input  frame,
    input  irdy,
    input  c_be,
    output trdy,
    output devsel
  );
endinterface

// File: rtl/pci_target.sv
// Memory-space PCI target: fast DEVSEL# decode of a MEM_WORDS x 32-bit window at BASE_ADDR,
// single and linear-burst reads/writes with WAIT_STATES initial wait cycles.
module pci_target #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned MEM_WORDS   = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  pci_target_if.slave bus,
  inout  wire  [31:0] ad
);

  localparam int unsigned IdxW        = $clog2(MEM_WORDS);
  localparam int unsigned TagLsb      = IdxW + 2;
  localparam logic [3:0]  CmdMemRead  = 4'b0110;
  localparam logic [3:0]  CmdMemWrite = 4'b0111;
  localparam logic [3:0]  WaitLen     = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    StIdle,
    StWait,  // DEVSEL# asserted, counting down initial wait cycles
    StData,
    StTurn
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            rd_q, rd_d;
  logic [31:0]     mem_q [MEM_WORDS];

  logic        cmd_rd;
  logic        cmd_wr;
  logic        hit;
  logic        claim;
  logic        xfer;
  logic        abandon;
  logic [3:0]  first_len;
  logic [31:0] rdata;
  logic        ad_oe;

  assign cmd_rd    = (bus.c_be == CmdMemRead);
  assign cmd_wr    = (bus.c_be == CmdMemWrite);
  assign hit       = (ad[31:TagLsb] == BASE_ADDR[31:TagLsb]);
  assign claim     = ~bus.frame & (cmd_rd | cmd_wr) & hit;
  // Reads need one extra cycle so the initiator can release AD before we drive it.
  assign first_len = WaitLen + {3'b000, cmd_rd};
  // TRDY# is low throughout StData, so a transfer completes whenever IRDY# is low there.
  assign xfer      = (state_q == StData) & ~bus.irdy;
  assign abandon   = bus.frame & bus.irdy;
  assign rdata     = mem_q[idx_q];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and transaction bookkeeping (wait count, word index, direction).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    unique case (state_q)
      StIdle: begin
        if (claim) begin
          rd_d  = cmd_rd;
          idx_d = ad[TagLsb-1:2];
          if (first_len == 4'd0) begin
            state_d = StData;
          end else begin
            state_d = StWait;
            cnt_d   = first_len;
          end
        end
      end
      StWait: begin
        if (abandon) begin
          state_d = StTurn;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d = StData;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StData: begin
        if (xfer) begin
          idx_d = idx_q + 1'b1;  // natural wrap at MEM_WORDS
          if (bus.frame) begin
            state_d = StTurn;
          end
        end else if (abandon) begin
          state_d = StTurn;
        end
      end
      StTurn: begin
        // FRAME# seen here belongs to someone else's turnaround; never claim it.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Transaction bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
      idx_q <= '0;
      rd_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      rd_q  <= rd_d;
    end
  end

  // Register file: byte-lane write on each completed write transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < MEM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (xfer && !rd_q) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (!bus.c_be[b]) begin
          mem_q[idx_q][8*b +: 8] <= ad[8*b +: 8];
        end
      end
    end
  end

  // Bus outputs decoded from state; all deasserted (high / released) by default.
  always_comb begin
    bus.trdy   = 1'b1;
    bus.devsel = 1'b1;
    ad_oe      = 1'b0;
    unique case (state_q)
      StWait: begin
        bus.devsel = 1'b0;
      end
      StData: begin
        bus.devsel = 1'b0;
        bus.trdy   = 1'b0;
        ad_oe      = rd_q;
      end
      default: begin
      end
    endcase
  end

  assign ad = ad_oe ? rdata : {32{1'bz}};

endmodule
